// File: rtl/seg_pkg.sv
// seg_pkg: shared BCD digit types and helpers for the counter and segment decoder
package seg_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  typedef logic [BCD_W-1:0] bcd_digit_t;
  function automatic bcd_digit_t bcd_sat(bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/bcd_tick_counter_if.sv
// bcd_tick_counter_if: control inputs and count/strobe outputs of the BCD tick counter
interface bcd_tick_counter_if #(parameter int DIGITS = 4);
  logic en;
  logic dir;
  logic clr;
  logic load;
  logic [4*DIGITS-1:0] load_val;
  logic [4*DIGITS-1:0] bcd_num;
  logic tick;
  logic wrap;
  modport master (output en, dir, clr, load, load_val, input bcd_num, tick, wrap);
  modport slave (input en, dir, clr, load, load_val, output bcd_num, tick, wrap);
endinterface

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD digit of next-value logic with ripple carry/borrow
module bcd_digit
  import seg_pkg::*;
(
  input  bcd_digit_t i_digit,
  input  logic       inc,
  input  logic       dec,
  input  logic       cin,
  output bcd_digit_t o_digit,
  output logic       cout
);
  logic w_max, w_min;
  assign w_max = i_digit == BCD_MAX;
  assign w_min = i_digit == '0;
  assign o_digit = !cin ? i_digit :
                   inc  ? (w_max ? '0 : i_digit + 4'd1) :
                   dec  ? (w_min ? BCD_MAX : i_digit - 4'd1) : i_digit;
  assign cout = cin & ((inc & w_max) | (dec & w_min));
endmodule

// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter: prescaled DIGITS-wide BCD up/down counter with tick and wrap strobes
module bcd_tick_counter
  import seg_pkg::*;
#(
  parameter int TICK_CYCLES = 25_000_000,
  parameter int DIGITS      = 4
) (
  input logic clk,
  input logic rst,
  bcd_tick_counter_if.slave bus
);
  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_CYCLES - 1);
  logic [PW-1:0] r_pcnt;
  logic [BCD_W*DIGITS-1:0] r_bcd, w_next, w_load;
  logic [DIGITS:0] w_chain;
  logic r_tick, r_wrap, w_step;
  assign w_step = bus.en && r_pcnt == P_LAST;
  // the least significant digit always moves on a step; higher digits follow the ripple
  assign w_chain[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit u_dig (
      .i_digit(r_bcd[BCD_W*i +: BCD_W]),
      .inc    (bus.dir),
      .dec    (!bus.dir),
      .cin    (w_chain[i]),
      .o_digit(w_next[BCD_W*i +: BCD_W]),
      .cout   (w_chain[i+1])
    );
    assign w_load[BCD_W*i +: BCD_W] = bcd_sat(bus.load_val[BCD_W*i +: BCD_W]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= '0;
      r_bcd  <= '0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      if (bus.clr) begin
        r_pcnt <= '0;
        r_bcd  <= '0;
      end else if (bus.load) begin
        r_pcnt <= '0;
        r_bcd  <= w_load;
      end else if (bus.en) begin
        r_pcnt <= w_step ? '0 : r_pcnt + 1'b1;
        if (w_step) begin
          r_bcd  <= w_next;
          r_tick <= 1'b1;
          r_wrap <= w_chain[DIGITS];
        end
      end
    end
  end
  assign bus.bcd_num = r_bcd;
  assign bus.tick    = r_tick;
  assign bus.wrap    = r_wrap;
endmodule

// File: tb/tb_bcd_tick_counter.sv
// tb_bcd_tick_counter: random and directed checks against a decimal-arithmetic reference model
module tb_bcd_tick_counter;
  localparam int TC = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  int m_val = 0;
  int m_p = 0;
  bit m_tick = 1'b0;
  bit m_wrap = 1'b0;
  bcd_tick_counter_if #(.DIGITS(2)) bus ();
  bcd_tick_counter #(.TICK_CYCLES(TC), .DIGITS(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
  function automatic int clamp_val(input logic [7:0] lv);
    int hi, lo;
    hi = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
    lo = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
    return hi * 10 + lo;
  endfunction
  task automatic model_reset();
    m_val = 0; m_p = 0; m_tick = 1'b0; m_wrap = 1'b0;
  endtask
  task automatic cyc();
    @(posedge clk);
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (bus.clr) begin
      m_val = 0; m_p = 0;
    end else if (bus.load) begin
      m_val = clamp_val(bus.load_val); m_p = 0;
    end else if (bus.en) begin
      if (m_p == TC - 1) begin
        m_p = 0;
        m_tick = 1'b1;
        m_wrap = bus.dir ? (m_val == 99) : (m_val == 0);
        m_val = bus.dir ? (m_val + 1) % 100 : (m_val + 99) % 100;
      end else m_p++;
    end
    #1;
    chk("bcd", bus.bcd_num, to_bcd(m_val));
    chk("tick", bus.tick, m_tick);
    chk("wrap", bus.wrap, m_wrap);
  endtask
  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask
  task automatic to_phase(input int ph);
    for (int k = 0; k < 2 * TC && m_p != ph; k++) cyc();
  endtask
  task automatic do_load(input logic [7:0] v);
    bus.load = 1'b1; bus.load_val = v;
    cyc();
    bus.load = 1'b0;
  endtask
  initial begin
    bus.en = 1'b0; bus.dir = 1'b1; bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bcd", bus.bcd_num, 0);
    chk("rst_tick", bus.tick, 0);
    chk("rst_wrap", bus.wrap, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.en = 1'b1;
    run(3);
    cyc();
    chk("edge4", bus.bcd_num, 8'h01);
    run(4);
    chk("edge8", bus.bcd_num, 8'h02);
    chk("edge8_tick", bus.tick, 1);
    do_load(8'h98);
    run(8);
    chk("up_wrap_val", bus.bcd_num, 8'h00);
    chk("up_wrap", bus.wrap, 1);
    do_load(8'h08);
    run(8);
    chk("carry_10", bus.bcd_num, 8'h10);
    bus.dir = 1'b0;
    do_load(8'h01);
    run(8);
    chk("down_wrap_val", bus.bcd_num, 8'h99);
    chk("down_wrap", bus.wrap, 1);
    bus.dir = 1'b1;
    to_phase(TC - 1);
    bus.clr = 1'b1; bus.load = 1'b1; bus.load_val = 8'h55;
    cyc();
    bus.clr = 1'b0; bus.load = 1'b0;
    chk("clr_prio", bus.bcd_num, 8'h00);
    chk("clr_notick", bus.tick, 0);
    to_phase(TC - 1);
    do_load(8'h55);
    chk("load_prio", bus.bcd_num, 8'h55);
    chk("load_notick", bus.tick, 0);
    run(3);
    chk("load_gap", bus.tick, 0);
    cyc();
    chk("load_next", bus.tick, 1);
    do_load(8'hFA);
    chk("clamp", bus.bcd_num, 8'h99);
    to_phase(2);
    bus.en = 1'b0;
    run(10);
    chk("pause_hold", bus.bcd_num, 8'h99);
    bus.en = 1'b1;
    cyc();
    chk("resume1", bus.tick, 0);
    cyc();
    chk("resume2", bus.tick, 1);
    for (int k = 0; k < 400; k++) begin
      bus.en = ($urandom_range(99) < 85);
      bus.dir = $urandom_range(1);
      bus.clr = ($urandom_range(99) < 3);
      bus.load = ($urandom_range(99) < 5);
      bus.load_val = 8'($urandom);
      cyc();
    end
    bus.en = 1'b1; bus.clr = 1'b0; bus.load = 1'b0; bus.dir = 1'b1;
    do_load(8'h41);
    to_phase(TC - 1);
    cyc();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_bcd", bus.bcd_num, 0);
    chk("arst_tick", bus.tick, 0);
    chk("arst_wrap", bus.wrap, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run(8);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/bcd_tick_counter.md
# bcd_tick_counter

Parametrised successor to the seven-segment demo counter. A prescaler divides `clk` down to a periodic tick, and a DIGITS-wide BCD up/down counter advances on each tick. The counter supports enable, synchronous clear and parallel load, and provides tick and wrap strobes. The BCD output feeds the segment scan/decoder directly, so no binary-to-BCD conversion is needed downstream.

## Interface
- `TICK_CYCLES`, default 25_000_000: clk cycles per count step; legal range ≥ 2.
- `DIGITS`, default 4: number of BCD digits; legal range 1..8.
- `clk`  input  1  system clock.
- `rst`  input  1  asynchronous, active-high reset.
- `en`  input  1  count enable; when low, the prescaler and value hold.
- `dir`  input  1  count direction: 1 = up, 0 = down.
- `clr`  input  1  synchronous clear of the value and the prescaler.
- `load`  input  1  synchronous parallel load.
- `load_val`  input  4*DIGITS  BCD load value; digit i occupies bits [4i+3:4i].
- `bcd_num`  output  4*DIGITS  current count in BCD, same digit packing as `load_val`.
- `tick`  output  1  one-cycle strobe marking each count step.
- `wrap`  output  1  one-cycle strobe when the count rolls over (all-9 to all-0, or all-0 to all-9).

## Operation
- Prescaler `pcnt` has width $clog2(TICK_CYCLES) and runs 0..TICK_CYCLES-1.
  - When `en`=1 it increments and wraps to 0.
  - When `en`=0 it holds its value and is not reset.
- Step condition: `step` = `en` & (`pcnt` == TICK_CYCLES-1).
- Per-cycle priority is `clr` > `load` > `step`:
  - `clr`: `bcd_num`←0, `pcnt`←0, `tick`←0, `wrap`←0.
  - `load`: `bcd_num`←`load_val` with each digit >9 clamped to 9; `pcnt`←0; no tick or wrap.
  - `step`, `dir`=1: BCD increment with ripple carry; a digit at 9 goes to 0 and carries. If all digits are 9, the result is all 0 and `wrap` is set.
  - `step`, `dir`=0: BCD decrement with ripple borrow; a digit at 0 goes to 9 and borrows. If all digits are 0, the result is all 9 and `wrap` is set.
- `dir` is sampled only on the step cycle. Changing `dir` between steps has no other effect.
- `clr` or `load` arriving on a step cycle suppresses that step, including its `tick` and `wrap`.

## Timing
- Reset values: `bcd_num`=0, `tick`=0, `wrap`=0, `pcnt`=0.
- All outputs are registered. `tick` and `wrap` rise on the same edge that updates `bcd_num`, and last exactly one cycle.
- With `en` held high from reset release, the first update happens on the TICK_CYCLES-th rising edge. After that, updates occur every TICK_CYCLES edges.
- After a `clr` or `load` edge, the next step happens TICK_CYCLES enabled cycles later.
- Deasserting `en` pauses counting. On re-enable, counting resumes with the remaining prescaler count; no cycles are lost.
- If `rst` asserts mid-period, all state clears immediately (asynchronous). Reset deassertion is assumed to be synchronised upstream.
- The ripple carry chain across the digits is purely combinational within one cycle. The design must meet timing at 50 MHz for DIGITS=8.

## Structure
- Shared package `seg_pkg`:
  - `BCD_W` = 4 and `BCD_MAX` = 4'd9.
  - `bcd_digit_t` typedef.
  - Clamp function `bcd_sat(digit)`, reused by the segment decoder.
- Sub-module `bcd_digit`, instantiated DIGITS times via generate:
  - Inputs: `inc`, `dec`, `cin`.
  - Outputs: digit value and `cout` (carry or borrow out).
  - Load and clear are handled in the parent; no prescaler logic lives in the digit.
- The top level contains the prescaler, the priority mux, the wrap detect, and the output registers.

## Test plan
All scenarios use TICK_CYCLES=4, DIGITS=2.
- **Reset and period:** release `rst`, `en`=1, `dir`=1 → `bcd_num` reads 8'h01 at edge 4 and 8'h02 at edge 8; `tick` is high for exactly one cycle at each of those edges; `wrap` stays 0.
- **Decimal carry and up wrap:** load 8'h98, `dir`=1 → sequence 8'h99, then 8'h00 with `wrap`=1 for one cycle; 8'h09 is followed by 8'h10 (never 8'h0A).
- **Down wrap:** load 8'h01, `dir`=0 → 8'h00, then 8'h99 with `wrap`=1.
- **Priority collision:** assert `clr` and `load`=8'h55 on a step cycle → `bcd_num`=0 and no `tick`. Assert `load` alone on a step cycle → 8'h55, no `tick`, next step 4 cycles later.
- **Load clamp:** `load_val`=8'hFA → `bcd_num`=8'h99.
- **Pause and async reset:** drop `en` when `pcnt`=2 for 10 cycles → no change in `bcd_num`; after re-enable the step occurs 2 cycles later. Pulse `rst` mid-period → all outputs 0 within the same cycle, without waiting for a clock edge.
